// File: rtl/tx_framer_pkg.sv
// Shared definitions for the TX lane framer: FSM states, the fixed line
// patterns and the 23-bit scrambler LFSR with its 32-bit-per-word step.
package tx_framer_pkg;

  typedef enum logic [1:0] {
    TRAIN  = 2'd0,
    MARKER = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // 1,0,1,0... first-out on the serial line (bit 0 leaves first).
  localparam logic [31:0] TRAIN_PAT  = 32'h5555_5555;
  localparam logic [31:0] MARKER_PAT = 32'hFFFF_FFFF;
  localparam logic [31:0] IDLE_PAT   = 32'h0000_0000;

  // x^23+x^21+x^16+x^8+x^5+x^2+1 -> feedback from state bits 22,20,15,7,4,1.
  localparam logic [22:0] LFSR_POLY_TAPS = 23'h50_8092;
  localparam logic [22:0] LFSR_SEED      = 23'h1D_BFBC;

  typedef struct packed {
    logic [22:0] next;
    logic [31:0] ks;
  } lfsr_out_t;

  // Fibonacci LFSR shifting left; the output bit is the MSB. Keystream bit i
  // is the output after i single steps, so bit 0 comes from the current state.
  function automatic lfsr_out_t lfsr_step32(input logic [22:0] s);
    lfsr_out_t   r;
    logic [22:0] t;
    t = s;
    r.ks = '0;
    for (int i = 0; i < 32; i++) begin
      r.ks[i] = t[22];
      t = {t[21:0], ^(t & LFSR_POLY_TAPS)};
    end
    r.next = t;
    return r;
  endfunction

endpackage

// File: rtl/tx_lane_framer_if.sv
// Framer bus: upstream valid/ready word stream, control levels and the
// word-rate output toward the serializer din.
//   master: upstream/control side (drives in_*, train_req, scramble_en)
//   slave : the framer (drives in_ready, dout, dout_is_data, link_active)
interface tx_lane_framer_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              train_req;
  logic              scramble_en;
  logic [WORD_W-1:0] dout;
  logic              dout_is_data;
  logic              link_active;

  modport master (
    output in_data, in_valid, train_req, scramble_en,
    input  in_ready, dout, dout_is_data, link_active
  );

  modport slave (
    input  in_data, in_valid, train_req, scramble_en,
    output in_ready, dout, dout_is_data, link_active
  );
endinterface

// File: rtl/tx_word_fifo.sv
// Small synchronous FIFO with wrap-bit pointers.
//   clk, rst : clock, async active-high reset (empties the FIFO)
//   push/din : write when push (caller gates with !full)
//   pop/dout : dout is the head word (show-ahead); pop advances it
//   full/empty : status from pointer compare
module tx_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;

  // Same index, different lap -> full; identical pointers -> empty.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/tx_lane_framer.sv
// Word-rate framer feeding the serializer din. Buffers the upstream stream,
// sends TRAIN_WORDS training words and a marker, then payload (optionally
// scrambled) or idle words. Retrain on train_req while ACTIVE.
//   clk, rst : word clock, async active-high reset
//   bus      : tx_lane_framer_if.slave (stream in, control, dout out)
// The scrambler delivers 32 keystream bits per word, so WORD_W is at most 32.
module tx_lane_framer
  import tx_framer_pkg::*;
#(
  parameter int SER_STAGES  = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int TRAIN_WORDS = 16
) (
  input  logic             clk,
  input  logic             rst,
  tx_lane_framer_if.slave  bus
);
  localparam int WORD_W = 2 ** SER_STAGES;
  localparam int CW     = $clog2(TRAIN_WORDS) + 1;

  localparam logic [WORD_W-1:0] TRAIN_W  = TRAIN_PAT[WORD_W-1:0];
  localparam logic [WORD_W-1:0] MARKER_W = MARKER_PAT[WORD_W-1:0];
  localparam logic [WORD_W-1:0] IDLE_W   = IDLE_PAT[WORD_W-1:0];

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [22:0]       lfsr_q, lfsr_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              is_data_q, is_data_d;

  logic              push, pop, full, empty;
  logic [WORD_W-1:0] fifo_q;
  lfsr_out_t         ks;

  // FIFO keeps accepting during TRAIN/MARKER; only fullness stalls upstream.
  assign push         = bus.in_valid && !full;
  assign bus.in_ready = !full;

  tx_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.in_data),
    .pop   (pop),
    .dout  (fifo_q),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    dout_d    = IDLE_W;
    is_data_d = 1'b0;
    pop       = 1'b0;
    ks        = lfsr_step32(lfsr_q);
    case (state_q)
      TRAIN: begin
        dout_d = TRAIN_W;
        if (cnt_q == CW'(TRAIN_WORDS - 1)) state_d = MARKER;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      MARKER: begin
        dout_d  = MARKER_W;
        state_d = ACTIVE;
        cnt_d   = '0;
        lfsr_d  = LFSR_SEED;   // keystream restarts with each link bring-up
      end
      ACTIVE: begin
        if (!empty) begin
          pop       = 1'b1;
          dout_d    = fifo_q ^ (bus.scramble_en ? ks.ks[WORD_W-1:0] : '0);
          is_data_d = 1'b1;
          lfsr_d    = ks.next;   // advances even when not scrambling
        end
        // This cycle still serves the FIFO; retrain starts next cycle.
        if (bus.train_req) begin
          state_d = TRAIN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = TRAIN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TRAIN;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      dout_q    <= '0;
      is_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      dout_q    <= dout_d;
      is_data_q <= is_data_d;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.dout_is_data = is_data_q;
  assign bus.link_active  = (state_q == ACTIVE);
endmodule

// File: tb/tb_tx_lane_framer.sv
module tb_tx_lane_framer;
  localparam int P_TRAIN = 0, P_MARKER = 1, P_ACTIVE = 2;
  localparam int NBITS = 32768;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tx_lane_framer_if #(.WORD_W(32)) bus ();

  tx_lane_framer #(.SER_STAGES(5), .FIFO_DEPTH(4), .TRAIN_WORDS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Keystream as a bit sequence: o[m+23] = o[m]^o[m+2]^o[m+7]^o[m+15]^o[m+18]^o[m+21],
  // first 23 bits are the seed MSB first.
  bit          ob [NBITS];
  int          m_phase, m_cnt, m_kidx;
  logic [31:0] m_q [$];
  logic [31:0] exp_dout;
  logic        exp_data, exp_link, exp_ready;

  function automatic logic [31:0] keyword(input int idx);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = ob[idx + i];
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = P_TRAIN; m_cnt = 0; m_kidx = 0;
    exp_dout = '0; exp_data = 0; exp_link = 0; exp_ready = 1;
  endtask

  // Outcome of the next clock edge given the inputs currently applied.
  task automatic model_edge(input logic v, input logic [31:0] d, input logic treq, input logic scr);
    logic        rdy;
    logic [31:0] w;
    rdy = (m_q.size() < 4);
    case (m_phase)
      P_TRAIN: begin
        exp_dout = 32'h5555_5555; exp_data = 0;
        m_cnt++;
        if (m_cnt == 16) begin m_phase = P_MARKER; m_cnt = 0; end
      end
      P_MARKER: begin
        exp_dout = 32'hFFFF_FFFF; exp_data = 0;
        m_phase = P_ACTIVE; m_kidx = 0;
      end
      default: begin
        if (m_q.size() > 0) begin
          w = m_q.pop_front();
          exp_dout = w ^ (scr ? keyword(m_kidx) : 32'h0);
          m_kidx += 32;
          exp_data = 1;
        end else begin
          exp_dout = 32'h0; exp_data = 0;
        end
        if (treq) m_phase = P_TRAIN;
      end
    endcase
    if (v && rdy) m_q.push_back(d);
    exp_link  = (m_phase == P_ACTIVE);
    exp_ready = (m_q.size() < 4);
  endtask

  task automatic tick();
    model_edge(bus.in_valid, bus.in_data, bus.train_req, bus.scramble_en);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    bus.in_valid = 0; bus.in_data = '0; bus.train_req = 0; bus.scramble_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n_train, marker_at;
    n_train = 0; marker_at = -1;
    rst = 1;
    bus.in_valid = 0; bus.in_data = '0; bus.train_req = 0; bus.scramble_en = 0;
    model_reset();
    #23;
    checks++;
    if ({bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got dout=%h d=%b l=%b r=%b exp 0/0/0/1", bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready);
    end
    @(posedge clk); #1 rst = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if ({bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready} !== {exp_dout, exp_data, exp_link, exp_ready}) begin
        errors++;
        $display("FAIL reset_seq c=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", c, bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready, exp_dout, exp_data, exp_link, exp_ready);
      end
      if (bus.dout === 32'h5555_5555) n_train++;
      if (bus.dout === 32'hFFFF_FFFF && marker_at < 0) marker_at = c;
    end
    checks++;
    if (n_train != 16 || marker_at != 17) begin
      errors++;
      $display("FAIL train_len got train=%0d marker_at=%0d exp 16/17", n_train, marker_at);
    end
    checks++;
    if (bus.dout !== 32'h0 || bus.link_active !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_marker got dout=%h l=%b exp 0/1", bus.dout, bus.link_active);
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] want [4];
    logic        wd [4];
    want[0] = 32'h0; want[1] = 32'hDEAD_BEEF; want[2] = 32'h0123_4567; want[3] = 32'h0;
    wd[0] = 0; wd[1] = 1; wd[2] = 1; wd[3] = 0;
    bus.scramble_en = 0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = (c < 2);
      bus.in_data  = (c == 0) ? 32'hDEAD_BEEF : 32'h0123_4567;
      tick();
      checks++;
      if ({bus.dout, bus.dout_is_data} !== {want[c], wd[c]} ||
          {bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready} !== {exp_dout, exp_data, exp_link, exp_ready}) begin
        errors++;
        $display("FAIL passthrough c=%0d got %h/%b exp %h/%b model %h", c, bus.dout, bus.dout_is_data, want[c], wd[c], exp_dout);
      end
    end
  endtask

  task automatic test_scramble();
    bus.train_req = 1; tick(); bus.train_req = 0;
    for (int i = 0; i < 40 && !bus.link_active; i++) tick();
    checks++;
    if (bus.link_active !== 1'b1) begin
      errors++;
      $display("FAIL scr_link_timeout got l=%b exp 1", bus.link_active);
    end
    bus.scramble_en = 1; bus.in_valid = 1; bus.in_data = 32'h0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) bus.in_valid = 0;
      tick();
      checks++;
      if ({bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready} !== {exp_dout, exp_data, exp_link, exp_ready}) begin
        errors++;
        $display("FAIL scramble_model c=%0d got %h/%b exp %h/%b", c, bus.dout, bus.dout_is_data, exp_dout, exp_data);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (bus.dout !== keyword((c - 1) * 32) || bus.dout_is_data !== 1'b1) begin
          errors++;
          $display("FAIL keystream_word%0d got %h exp %h", c - 1, bus.dout, keyword((c - 1) * 32));
        end
      end
    end
    bus.scramble_en = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] acc [$];
    logic [31:0] w;
    int          got;
    do_reset();
    bus.in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      bus.in_data = $urandom();
      if (bus.in_ready) acc.push_back(bus.in_data);
      tick();
    end
    bus.in_valid = 0;
    checks++;
    if (acc.size() != 4 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accepts got %0d ready=%b exp 4/0", acc.size(), bus.in_ready);
    end
    got = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready} !== {exp_dout, exp_data, exp_link, exp_ready}) begin
        errors++;
        $display("FAIL bp_model c=%0d got %h/%b exp %h/%b", c, bus.dout, bus.dout_is_data, exp_dout, exp_data);
      end
      if (bus.dout_is_data === 1'b1) begin
        w = (got < 4) ? acc[got] : 32'hXXXX_XXXX;
        checks++;
        if (got >= 4 || bus.dout !== w) begin
          errors++;
          $display("FAIL bp_order idx=%0d got %h exp %h", got, bus.dout, w);
        end
        got++;
      end
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL bp_count got %0d exp 4", got);
    end
  endtask

  task automatic test_retrain();
    logic [31:0] w [4];
    do_reset();
    bus.scramble_en = 1;
    bus.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom(); bus.in_data = w[i]; tick();
    end
    bus.in_valid = 0;
    for (int i = 0; i < 40 && !bus.link_active; i++) tick();
    tick(); tick();                      // w0, w1 leave; two words remain
    bus.train_req = 1; tick(); bus.train_req = 0;
    checks++;
    if (bus.dout !== (w[2] ^ keyword(64)) || bus.dout_is_data !== 1'b1) begin
      errors++;
      $display("FAIL retrain_last_active got %h exp %h", bus.dout, w[2] ^ keyword(64));
    end
    for (int c = 1; c <= 18; c++) begin
      tick();
      checks++;
      if ({bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready} !== {exp_dout, exp_data, exp_link, exp_ready}) begin
        errors++;
        $display("FAIL retrain_model c=%0d got %h/%b exp %h/%b", c, bus.dout, bus.dout_is_data, exp_dout, exp_data);
      end
      if (c <= 16 && bus.dout !== 32'h5555_5555) begin
        errors++; checks++;
        $display("FAIL retrain_train c=%0d got %h exp 55555555", c, bus.dout);
      end
    end
    checks++;
    if (bus.dout !== (w[3] ^ keyword(0)) || bus.dout_is_data !== 1'b1) begin
      errors++;
      $display("FAIL retrain_reseed got %h exp %h", bus.dout, w[3] ^ keyword(0));
    end
    bus.scramble_en = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid    = ($urandom_range(0, 9) < 7);
      bus.in_data     = $urandom();
      bus.scramble_en = $urandom_range(0, 1);
      bus.train_req   = ($urandom_range(0, 31) == 0);
      tick();
      checks++;
      if ({bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready} !== {exp_dout, exp_data, exp_link, exp_ready}) begin
        errors++;
        $display("FAIL random c=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", c, bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready, exp_dout, exp_data, exp_link, exp_ready);
      end
    end
    bus.in_valid = 0; bus.train_req = 0; bus.scramble_en = 0;
  endtask

  task automatic test_reset_mid();
    int leaked;
    leaked = 0;
    for (int i = 0; i < 40 && !bus.link_active; i++) tick();
    bus.in_valid = 1;
    for (int i = 0; i < 3; i++) begin bus.in_data = $urandom(); tick(); end
    #2 rst = 1;
    bus.in_valid = 0;
    model_reset();
    #1;
    checks++;
    if ({bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got %h/%b/%b/%b exp 0/0/0/1", bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready);
    end
    @(posedge clk); #1 rst = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if ({bus.dout, bus.dout_is_data, bus.link_active, bus.in_ready} !== {exp_dout, exp_data, exp_link, exp_ready}) begin
        errors++;
        $display("FAIL post_reset c=%0d got %h/%b exp %h/%b", c, bus.dout, bus.dout_is_data, exp_dout, exp_data);
      end
      if (bus.dout_is_data === 1'b1) leaked++;
    end
    checks++;
    if (leaked != 0) begin
      errors++;
      $display("FAIL reset_leak got %0d data words exp 0", leaked);
    end
  endtask

  initial begin
    logic [22:0] seed;
    seed = 23'h1D_BFBC;
    for (int j = 0; j < 23; j++) ob[j] = seed[22 - j];
    for (int m = 0; m + 23 < NBITS; m++)
      ob[m + 23] = ob[m] ^ ob[m + 2] ^ ob[m + 7] ^ ob[m + 15] ^ ob[m + 18] ^ ob[m + 21];

    test_reset();
    test_passthrough();
    test_scramble();
    test_backpressure();
    test_retrain();
    test_random();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_lane_framer.md
Name: tx_lane_framer

Overview:
- Word-rate framing stage that sits directly upstream of the tree serializer.
- Its registered parallel output drives the serializer's din bus.
- Runs on the slowest divided serializer clock (word clock), so one dout word is consumed per clk cycle.
- Buffers an upstream valid/ready word stream, emits a training pattern plus a start marker, then emits payload words (optionally scrambled) or idle words.

Parameters:
- SER_STAGES, 5: serializer tree depth; WORD_W = 2**SER_STAGES (32).
- FIFO_DEPTH, 4: input buffer depth in words; power of two, ≥2.
- TRAIN_WORDS, 16: number of training words per training sequence; ≥1.

Ports:
- clk  input  1  word clock (slowest serializer clock).
- rst  input  1  asynchronous active-high reset.
- in_data  input  WORD_W  payload word; bit 0 is serialized first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; a transfer occurs on in_valid && in_ready at posedge.
- train_req  input  1  level; requests a retrain.
- scramble_en  input  1  XOR payload with the LFSR; sampled at each payload pop.
- dout  output  WORD_W  word to the serializer din.
- dout_is_data  output  1  dout holds a payload word this cycle.
- link_active  output  1  state is ACTIVE.

Behaviour:
- Reset (async assert, sync release):
  - state=TRAIN, train count=0, FIFO empty.
  - dout=0, dout_is_data=0, link_active=0.
  - LFSR=seed; in_ready=1 (FIFO accepts during training).
- All outputs except in_ready are registered. in_ready = !full, combinational from the FIFO count.
- States:
  - TRAIN: each cycle dout<=TRAIN_PAT (32'h5555_5555, i.e. 1,0,1,0… first-out), count++. When count==TRAIN_WORDS-1, go to MARKER.
  - MARKER: one cycle, dout<=all-ones. Go to ACTIVE; count<=0; LFSR<=seed.
  - ACTIVE, FIFO non-empty: pop; dout<=data ^ (scramble_en ? lfsr_word : 0); dout_is_data<=1; LFSR advances 32 bits.
  - ACTIVE, FIFO empty: dout<=IDLE (all zeros); dout_is_data<=0; LFSR holds.
- Retrain:
  - train_req=1 sampled in ACTIVE: the current cycle still emits per ACTIVE rules, then the next state is TRAIN.
  - The FIFO is preserved; payload resumes after the next MARKER.
  - train_req in TRAIN/MARKER is ignored; a held level re-enters TRAIN only after reaching ACTIVE.
- LFSR:
  - 23-bit, polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, seed 23'h1DBFBC.
  - lfsr_word bit i = LFSR output after i single-bit steps (bit 0 first).
- Latency: a word accepted at edge N into an empty FIFO while in ACTIVE appears on dout after edge N+1.
- Push and pop in the same cycle: both occur; count unchanged.
  - When full, in_ready=0, so no push; a pop in that cycle frees a slot for the next cycle.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits with wrap bit. Full = same index, different wrap bit.
- Reset mid-operation: FIFO contents are discarded, and the sequence restarts from TRAIN.

Decomposition:
- Package tx_framer_pkg contains:
  - state enum {TRAIN, MARKER, ACTIVE};
  - TRAIN_PAT, MARKER_PAT, IDLE_PAT;
  - LFSR_POLY_TAPS, LFSR_SEED;
  - function lfsr_step32 (returns the next state and the 32-bit keystream).
- Sub-module: tx_word_fifo (parameterized WIDTH/DEPTH; synchronous push/pop, full/empty, async reset). The FSM and scrambler live in the top.

Test Plan:
- Reset release, in_valid=0:
  - 16 cycles of dout=32'h5555_5555, then 1 cycle of 32'hFFFF_FFFF, then 32'h0000_0000 with link_active=1.
- In ACTIVE, scramble_en=0, push 32'hDEAD_BEEF, 32'h0123_4567:
  - Each appears on dout one cycle after acceptance, in order, with dout_is_data=1, then idle zeros.
- scramble_en=1, first payload after MARKER = 32'h0:
  - dout equals the first 32 keystream bits from seed 23'h1DBFBC (golden model).
  - The second zero word equals the next 32 bits.
- Backpressure: hold in_valid=1 while in TRAIN:
  - in_ready drops after 4 accepts.
  - The 4 words emerge in order immediately after MARKER; no loss or duplicate.
- train_req pulse while FIFO holds 2 words:
  - One ACTIVE word is emitted (first FIFO word).
  - Then 16 TRAIN words + MARKER, then the second FIFO word.
  - The LFSR is reseeded for that word.
- Assert rst mid-payload: outputs go to 0 immediately (async); after release the TRAIN sequence restarts and no pre-reset words are emitted.
